// File: rtl/bist_pkg.sv
// Shared BIST definitions: sequencer state encoding and default MISR/TPG dimensions.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        RUN     = 3'd2,
        SETTLE  = 3'd3,
        COMPARE = 3'd4,
        DONE    = 3'd5
    } bist_state_e;

    localparam int BIST_SIG_W   = 4;
    localparam int BIST_NUM_PAT = 8;
    localparam int BIST_CNT_W   = 4;

    function automatic logic state_is_busy(input bist_state_e s);
        return (s == CLEAR) || (s == RUN) || (s == SETTLE);
    endfunction

endpackage

// File: rtl/bist_pattern_counter.sv
// Up-counter of applied patterns with synchronous clear, enable and a terminal-count flag.
module bist_pattern_counter #(
    parameter int               CNT_W = 4,
    parameter logic [CNT_W-1:0] TERM  = '1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == TERM);

endmodule

// File: rtl/bist_signature_checker.sv
// BIST sequencer: clears the MISR, runs NUM_PAT patterns, then grades the signature.
// Optional BIST_SIG_CAPTURE_EN keeps the compared signature for diagnosis readout.
//
// state   | meaning
// IDLE    | waiting for start
// CLEAR   | MISR held in clear, pattern count zeroed
// RUN     | pattern generator advancing one pattern per clock
// SETTLE  | generator paused while the MISR absorbs the last response
// COMPARE | signature sampled against GOLDEN_SIG
// DONE    | verdict presented until restart or abort
module bist_signature_checker
    import bist_pkg::*;
#(
    parameter int               SIG_W      = BIST_SIG_W,
    parameter int               NUM_PAT    = BIST_NUM_PAT,
    parameter int               CNT_W      = BIST_CNT_W,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [SIG_W-1:0] signature_in,
    output logic             ora_rst_n,
    output logic             tpg_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [CNT_W-1:0] pat_cnt,
    output logic [SIG_W-1:0] sig_captured
);

    if ((NUM_PAT < 1) || (NUM_PAT >= (2 ** CNT_W))) begin : g_num_pat_check
        $error("bist_signature_checker: NUM_PAT must lie in 1..2**CNT_W-1");
    end

    bist_state_e state_q;
    bist_state_e state_d;

    logic ora_rst_n_q, ora_rst_n_d;
    logic tpg_en_q, tpg_en_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic pass_q, pass_d;
    logic fail_q, fail_d;

    logic cnt_clr;
    logic cnt_en;
    logic cnt_tc;
    logic sig_match;

    assign sig_match = (signature_in == GOLDEN_SIG);

    // Zero the count on entry to CLEAR so a re-run never shows the previous total.
    assign cnt_clr = (state_d == CLEAR) || (state_d == IDLE);
    assign cnt_en  = (state_q == RUN);

    bist_pattern_counter #(
        .CNT_W (CNT_W),
        .TERM  (CNT_W'(NUM_PAT - 1))
    ) u_pat_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (pat_cnt),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start) state_d = CLEAR;
                CLEAR:   state_d = RUN;
                RUN:     if (cnt_tc) state_d = SETTLE;
                SETTLE:  state_d = COMPARE;
                COMPARE: state_d = DONE;
                DONE:    if (start) state_d = CLEAR;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they come straight from flops.
    always_comb begin
        ora_rst_n_d = (state_d != CLEAR);
        tpg_en_d    = (state_d == RUN);
        busy_d      = state_is_busy(state_d);
        done_d      = (state_d == DONE);
        pass_d      = pass_q;
        fail_d      = fail_q;
        if ((state_q == COMPARE) && (state_d == DONE)) begin
            pass_d = sig_match;
            fail_d = ~sig_match;
        end else if (state_d != DONE) begin
            pass_d = 1'b0;
            fail_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ora_rst_n_q <= 1'b1;
            tpg_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            ora_rst_n_q <= ora_rst_n_d;
            tpg_en_q    <= tpg_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
        end
    end

    assign ora_rst_n = ora_rst_n_q;
    assign tpg_en    = tpg_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;

`ifdef BIST_SIG_CAPTURE_EN
    logic [SIG_W-1:0] sig_captured_q;
    logic [SIG_W-1:0] sig_captured_d;

    always_comb begin
        sig_captured_d = sig_captured_q;
        if ((state_d == IDLE) || (state_d == CLEAR)) begin
            sig_captured_d = '0;
        end else if ((state_q == COMPARE) && (state_d == DONE)) begin
            sig_captured_d = signature_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sig_captured_q <= '0;
        end else begin
            sig_captured_q <= sig_captured_d;
        end
    end

    assign sig_captured = sig_captured_q;
`else
    assign sig_captured = '0;
`endif

endmodule
